// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-requester memory arbiter: FSM states,
// read/write encoding, default widths and the round-robin pick helper.
package mem_arbiter_pkg;

    localparam int DEFAULT_ADDR_W   = 64;
    localparam int DEFAULT_DATA_W   = 64;
    localparam int DEFAULT_WAIT_MAX = 15;

    // Wait counter width; WAIT_MAX is limited to 1..255 so 8 bits suffice.
    localparam int WAIT_W  = 8;
    localparam int NUM_REQ = 2;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Round-robin pick between two requesters. prio names the requester
    // that wins a tie; a lone requester always wins.
    function automatic logic rr_pick(input logic [NUM_REQ-1:0] req, input logic prio);
        if (req[0] && req[1]) begin
            return prio;
        end
        return req[1];
    endfunction

endpackage

// File: rtl/mem_arbiter_wait_timer.sv
// Wait counter for the ACCESS phase: cleared when an access starts, counts
// cycles spent without a memory response, flags the last allowed cycle.
module wait_timer
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH = WAIT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] count_reg;

    // Count ACCESS cycles without mem_ready; clear dominates enable.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    // High in the cycle whose unanswered wait would make the count reach
    // the limit, so the owner leaves ACCESS after exactly `limit` cycles.
    assign expired = (count_reg == (limit - WIDTH'(1)));

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester round-robin memory arbiter. One access at a time passes
// through IDLE -> ACCESS -> DONE; a wait timer aborts accesses that the
// memory never answers and reports them with err=1.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int WAIT_MAX = DEFAULT_WAIT_MAX   // legal range 1..255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              rw0,
    input  logic              rw1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_datao,
    output logic              mem_rw,
    output logic              mem_valid,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_ready
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX);

    state_t state_reg, state_next;

    // owner: requester currently holding the bus; prio: who wins a tie next.
    logic owner_reg, owner_next;
    logic prio_reg, prio_next;

    logic              rw_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              err_reg;

    logic [NUM_REQ-1:0] req_vec;
    logic [NUM_REQ-1:0] gnt_vec;
    logic [NUM_REQ-1:0] done_vec;
    logic               any_req;
    logic               winner;

    logic latch_en;
    logic ready_hit;
    logic timeout_hit;
    logic timer_clear;
    logic timer_enable;
    logic timer_expired;

    assign req_vec = {req1, req0};
    assign any_req = |req_vec;
    assign winner  = rr_pick(req_vec, prio_reg);

    wait_timer #(
        .WIDTH (WAIT_W)
    ) u_wait_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (timer_clear),
        .enable  (timer_enable),
        .limit   (WAIT_LIMIT),
        .expired (timer_expired)
    );

    // State, owner and round-robin pointer registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg <= IDLE;
            owner_reg <= 1'b0;
            prio_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            owner_reg <= owner_next;
            prio_reg  <= prio_next;
        end
    end

    // Next-state logic: arbitrate in IDLE, wait for memory or timeout in
    // ACCESS, spend exactly one cycle in DONE for the completion pulse.
    always_comb begin
        state_next   = state_reg;
        owner_next   = owner_reg;
        prio_next    = prio_reg;
        latch_en     = 1'b0;
        ready_hit    = 1'b0;
        timeout_hit  = 1'b0;
        timer_clear  = 1'b0;
        timer_enable = 1'b0;
        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    latch_en    = 1'b1;
                    owner_next  = winner;
                    prio_next   = ~winner;
                    timer_clear = 1'b1;
                    state_next  = ACCESS;
                end
            end
            ACCESS: begin
                // A response in the last allowed cycle still counts as success.
                if (mem_ready) begin
                    ready_hit  = 1'b1;
                    state_next = DONE;
                end else if (timer_expired) begin
                    timeout_hit = 1'b1;
                    state_next  = DONE;
                end else begin
                    timer_enable = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Command latch at grant time and result capture at the end of ACCESS.
    always_ff @(posedge clock) begin
        if (reset) begin
            rw_reg    <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
            rdata_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            if (latch_en) begin
                rw_reg    <= winner ? rw1    : rw0;
                addr_reg  <= winner ? addr1  : addr0;
                wdata_reg <= winner ? wdata1 : wdata0;
            end
            if (ready_hit) begin
                err_reg <= 1'b0;
                if (rw_reg == RW_READ) begin
                    rdata_reg <= mem_data;
                end
            end else if (timeout_hit) begin
                err_reg   <= 1'b1;
                rdata_reg <= '0;
            end
        end
    end

    // Per-requester grant and completion decode from the owner register.
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req_out
        assign gnt_vec[gi]  = (state_reg != IDLE) && (owner_reg == 1'(gi));
        assign done_vec[gi] = (state_reg == DONE) && (owner_reg == 1'(gi));
    end

    assign gnt0  = gnt_vec[0];
    assign gnt1  = gnt_vec[1];
    assign done0 = done_vec[0];
    assign done1 = done_vec[1];
    assign rdata = rdata_reg;
    assign err   = err_reg;

    // Memory command is only driven while an access is in flight.
    assign mem_valid   = (state_reg == ACCESS);
    assign mem_address = mem_valid ? addr_reg : '0;
    assign mem_rw      = mem_valid & rw_reg;
    assign mem_datao   = (mem_valid && (rw_reg == RW_WRITE)) ? wdata_reg : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected completions,
// a negedge monitor pops and compares on every done pulse.
module tb_mem_arbiter;

    localparam int ADDR_W   = 64;
    localparam int DATA_W   = 64;
    localparam int WAIT_MAX = 15;

    logic              clock = 1'b0;
    logic              reset;
    logic              req0, req1, rw0, rw1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, done0, done1, err;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_datao;
    logic              mem_rw, mem_valid;
    logic [DATA_W-1:0] mem_data;
    logic              mem_ready;

    typedef struct {
        int          who;
        logic        err;
        logic [63:0] rdata;
        int          cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    mem_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .WAIT_MAX (WAIT_MAX)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req0        (req0),
        .req1        (req1),
        .rw0         (rw0),
        .rw1         (rw1),
        .addr0       (addr0),
        .addr1       (addr1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .done0       (done0),
        .done1       (done1),
        .rdata       (rdata),
        .err         (err),
        .mem_address (mem_address),
        .mem_datao   (mem_datao),
        .mem_rw      (mem_rw),
        .mem_valid   (mem_valid),
        .mem_data    (mem_data),
        .mem_ready   (mem_ready)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_gnt"},      {62'd0, gnt1, gnt0}, 64'd0);
        check({tag, "_done"},     {62'd0, done1, done0}, 64'd0);
        check({tag, "_rdata"},    rdata, 64'd0);
        check({tag, "_err"},      {63'd0, err}, 64'd0);
        check({tag, "_mem_valid"}, {63'd0, mem_valid}, 64'd0);
        check({tag, "_mem_rw"},   {63'd0, mem_rw}, 64'd0);
        check({tag, "_mem_addr"}, mem_address, 64'd0);
        check({tag, "_mem_datao"}, mem_datao, 64'd0);
    endtask

    // Monitor: grants must never overlap; every done pulse is matched
    // against the oldest expected completion.
    always @(negedge clock) begin
        if (!reset) begin
            if (gnt0 && gnt1) begin
                n_checks++;
                n_fail++;
                $display("FAIL gnt_onehot: got gnt0=1 gnt1=1, expected at most one (cycle %0d)", cyc);
            end
            if (done0 || done1) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done0=%0b done1=%0b, expected none (cycle %0d)",
                             done0, done1, cyc);
                end else begin
                    mon_e = sb_q.pop_front();
                    $display("txn: requester %0d done at cycle %0d err=%0b rdata=0x%0h",
                             done1 ? 1 : 0, cyc, err, rdata);
                    check("done_owner", {62'd0, done1, done0}, (mon_e.who == 0) ? 64'd1 : 64'd2);
                    check("done_err", {63'd0, err}, {63'd0, mon_e.err});
                    check("done_rdata", rdata, mon_e.rdata);
                    check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
                end
            end
        end
    end

    // One access from a single requester on an idle bus. ready_at is the
    // ACCESS cycle (1-based) carrying mem_ready, 0 for never; n_access is
    // the hand-computed number of ACCESS cycles.
    task automatic do_access(input int who, input logic rw, input logic [63:0] addr,
                             input logic [63:0] wdata, input int ready_at,
                             input logic [63:0] mdata, input int n_access,
                             input logic exp_err, input logic [63:0] exp_rdata);
        exp_t e;
        if (who == 0) begin
            req0 = 1'b1; rw0 = rw; addr0 = addr; wdata0 = wdata;
        end else begin
            req1 = 1'b1; rw1 = rw; addr1 = addr; wdata1 = wdata;
        end
        step();
        e.who = who; e.err = exp_err; e.rdata = exp_rdata; e.cyc = cyc + n_access;
        sb_q.push_back(e);
        // Inputs after the latch point must be ignored.
        if (who == 0) begin
            req0 = 1'b0; rw0 = ~rw; addr0 = ~addr; wdata0 = ~wdata;
        end else begin
            req1 = 1'b0; rw1 = ~rw; addr1 = ~addr; wdata1 = ~wdata;
        end
        for (int n = 1; n <= n_access; n++) begin
            mem_ready = (n == ready_at);
            mem_data  = mdata;
            check("acc_gnt", {62'd0, gnt1, gnt0}, (who == 0) ? 64'd1 : 64'd2);
            check("acc_mem_valid", {63'd0, mem_valid}, 64'd1);
            check("acc_mem_addr", mem_address, addr);
            check("acc_mem_rw", {63'd0, mem_rw}, {63'd0, rw});
            check("acc_mem_datao", mem_datao, rw ? 64'd0 : wdata);
            step();
        end
        mem_ready = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1;
        req0 = 0; req1 = 0; rw0 = 0; rw1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        mem_data = '0; mem_ready = 1'b0;
        repeat (3) step();
        check_outputs_zero("reset");
        reset = 1'b0;
        step();

        // Read, memory answers in the first ACCESS cycle: 3-cycle latency.
        do_access(0, 1'b1, 64'h10, 64'h999, 1, 64'hDEAD, 1, 1'b0, 64'hDEAD);

        // mem_ready outside ACCESS is ignored.
        mem_ready = 1'b1; mem_data = 64'hFFFF;
        repeat (2) begin
            step();
            check("idle_gnt", {62'd0, gnt1, gnt0}, 64'd0);
            check("idle_mem_valid", {63'd0, mem_valid}, 64'd0);
            check("idle_rdata_hold", rdata, 64'hDEAD);
        end
        mem_ready = 1'b0;
        step();

        // Write with 4 wait cycles; rdata keeps the last read value.
        do_access(1, 1'b0, 64'h20, 64'h55, 5, 64'h1234, 5, 1'b0, 64'hDEAD);

        // Contention: both held, grants alternate 0,1,0,1, back-to-back.
        req0 = 1'b1; req1 = 1'b1; rw0 = 1'b1; rw1 = 1'b1;
        addr0 = 64'h100; addr1 = 64'h200;
        for (int k = 0; k < 4; k++) begin
            exp_t e;
            step();
            check("cont_gnt", {62'd0, gnt1, gnt0}, (k % 2 == 0) ? 64'd1 : 64'd2);
            check("cont_mem_addr", mem_address, (k % 2 == 0) ? 64'h100 : 64'h200);
            e.who = k % 2; e.err = 1'b0; e.rdata = 64'hA0 + 64'(k); e.cyc = cyc + 1;
            sb_q.push_back(e);
            mem_ready = 1'b1;
            mem_data  = 64'hA0 + 64'(k);
            step();
            mem_ready = 1'b0;
            step();
        end
        req0 = 1'b0; req1 = 1'b0;
        step();

        // Timeout: no response for WAIT_MAX cycles gives err=1, rdata=0.
        do_access(0, 1'b1, 64'h30, 64'h0, 0, 64'hBAD, 15, 1'b1, 64'h0);

        // Response in the very cycle the counter would reach WAIT_MAX.
        do_access(1, 1'b1, 64'h40, 64'h0, 15, 64'hBEEF, 15, 1'b0, 64'hBEEF);

        // Reset in the middle of an access drops it without a done pulse.
        req0 = 1'b1; rw0 = 1'b1; addr0 = 64'h70;
        step();
        check("rst_pre_gnt", {62'd0, gnt1, gnt0}, 64'd1);
        req0 = 1'b0;
        reset = 1'b1;
        step();
        check_outputs_zero("midrst");
        reset = 1'b0;

        // After reset requester 0 wins a tie even though it was last granted.
        req0 = 1'b1; req1 = 1'b1; rw0 = 1'b1; rw1 = 1'b1;
        addr0 = 64'h50; addr1 = 64'h60;
        step();
        check("post_rst_gnt", {62'd0, gnt1, gnt0}, 64'd1);
        check("post_rst_addr", mem_address, 64'h50);
        begin
            exp_t e;
            e.who = 0; e.err = 1'b0; e.rdata = 64'h77; e.cyc = cyc + 1;
            sb_q.push_back(e);
        end
        req0 = 1'b0; req1 = 1'b0;
        mem_ready = 1'b1; mem_data = 64'h77;
        step();
        mem_ready = 1'b0;
        repeat (3) step();

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 64, width of the memory address.
REQ-002 Parameter: DATA_W, default 64, width of the memory data.
REQ-003 Parameter: WAIT_MAX, default 15, maximum ACCESS cycles spent waiting for mem_ready before abort; legal range 1..255.
REQ-004 Port: clock, in, 1, the single clock; all state updates on the rising edge.
REQ-005 Port: reset, in, 1, synchronous, active-high.
REQ-006 Ports: req0/req1, in, 1, access request from requester 0 (CPU) and requester 1 (loader/DMA).
REQ-007 Ports: rw0/rw1, in, 1, 1 = read, 0 = write.
REQ-008 Ports: addr0/addr1, in, ADDR_W, request address.
REQ-009 Ports: wdata0/wdata1, in, DATA_W, write data.
REQ-010 Ports: gnt0/gnt1, out, 1, requester owns the bus (ACCESS and DONE).
REQ-011 Ports: done0/done1, out, 1, one-cycle completion pulse.
REQ-012 Port: rdata, out, DATA_W, read data; valid while done0 or done1 is high.
REQ-013 Port: err, out, 1, timeout flag; valid while done0 or done1 is high.
REQ-014 Ports: mem_address (out, ADDR_W), mem_datao (out, DATA_W), mem_rw (out, 1), mem_valid (out, 1): memory command.
REQ-015 Ports: mem_data (in, DATA_W), mem_ready (in, 1): memory response.

Function
REQ-016 The FSM SHALL have three states, IDLE, ACCESS and DONE, and handle exactly one access at a time.
REQ-017 In IDLE with at least one reqN high, the block SHALL latch the winner's rw/addr/wdata and move to ACCESS on the next edge.
REQ-018 Arbitration SHALL be round-robin: on simultaneous requests, the requester not granted last wins; after reset requester 0 has priority.
REQ-019 In ACCESS: mem_valid=1; mem_address/mem_rw driven from the latch; mem_datao = latched wdata on a write, 0 on a read.
REQ-020 In ACCESS, mem_ready=1 SHALL capture mem_data into rdata (reads only; rdata is held unchanged on writes) and move to DONE with err=0.
REQ-021 A wait counter SHALL clear on entry to ACCESS and increment on each ACCESS cycle without mem_ready; on reaching WAIT_MAX, the FSM SHALL move to DONE with err=1 and rdata=0.
REQ-022 mem_ready arriving in the same cycle the counter reaches WAIT_MAX SHALL count as success (err=0).
REQ-023 In DONE, doneN of the owner SHALL be high for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-024 Minimum latency SHALL be 3 cycles (request sampled in IDLE -> done pulse), occurring when mem_ready is high in the first ACCESS cycle.
REQ-025 Deasserting reqN during ACCESS SHALL NOT abort the transaction; input changes after the latch point SHALL be ignored.
REQ-026 mem_ready outside ACCESS SHALL be ignored.
REQ-027 gntN SHALL be one-hot or zero; never both high.
REQ-028 Back-to-back: a request held through DONE SHALL be re-arbitrated in the following IDLE cycle.

Reset
REQ-029 On reset, the FSM SHALL go to IDLE, the round-robin pointer to requester-0 priority, and the wait counter to 0.
REQ-030 On reset, all outputs SHALL be 0 (gnt, done, rdata, err, mem_*), including when reset is asserted mid-ACCESS; the in-flight access is dropped with no done pulse.

Structure
REQ-031 A shared package SHALL hold the state enum (IDLE/ACCESS/DONE), the RW_READ=1/RW_WRITE=0 constants, and the default widths.
REQ-032 The wait counter SHALL be a sub-module, wait_timer (clear, enable, limit input, expired output).

Verification
REQ-033 Read: req0=1, rw0=1, addr0=0x10; mem_ready in the first ACCESS cycle with mem_data=0xDEAD -> done0 on cycle 3, rdata=0xDEAD, err=0.
REQ-034 Write: req1=1, rw1=0, addr1=0x20, wdata1=0x55; mem_ready after 4 wait cycles -> mem_rw=0, mem_datao=0x55 throughout ACCESS; done1 pulse, err=0.
REQ-035 Contention: req0 and req1 held high for 4 transactions -> grants alternate 0,1,0,1, and gnt is never both high.
REQ-036 Timeout: WAIT_MAX=15, mem_ready never asserted -> done pulse after 15 ACCESS cycles, err=1, rdata=0.
REQ-037 Reset while in ACCESS -> next cycle IDLE, all outputs 0, no done pulse; a subsequent simultaneous request grants requester 0.
